// File: rtl/ob_ddr_writeback_ctrl_pkg.sv
// Shared types and elaboration helpers for the OB-to-DDR writeback controller.
// Holds the FSM encoding, ceil-log2 and the output word-width derivation.
package ob_ddr_writeback_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_FLUSH
   } wb_state_e;

   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int word_width(input int data_len, input int buffer_num);
      return data_len * buffer_num;
   endfunction

endpackage

// File: rtl/ob_ddr_writeback_ctrl_if.sv
// Bus bundle between the writeback controller, the OB read port and the DDR write master.
// The controller drives the master side; OB memory and DDR FIFO sit on the slave side.
interface ob_ddr_writeback_ctrl_if #(
   parameter int DDR_ADDR_LEN = 32,
   parameter int ADDR_LEN     = 16,
   parameter int SINGLE_LEN   = 24,
   parameter int W            = 128
);
   logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
   logic [SINGLE_LEN-1:0]   ddr_len;
   logic                    ddr_conf;
   logic                    ddr_fifo_full;
   logic                    ddr_fifo_wr;
   logic [W-1:0]            ddr_fifo_data;
   logic [ADDR_LEN-1:0]     ob_addr;
   logic                    ob_en;
   logic [W-1:0]            ob_data;

   modport master (
      output ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_wr, ddr_fifo_data,
      output ob_addr, ob_en,
      input  ddr_fifo_full, ob_data
   );

   modport slave (
      input  ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_wr, ddr_fifo_data,
      input  ob_addr, ob_en,
      output ddr_fifo_full, ob_data
   );
endinterface

// File: rtl/ob_ddr_writeback_ctrl_sync_skid_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
// Writes when full and reads when empty are ignored.
module ob_ddr_writeback_ctrl_sync_skid_fifo
   import ob_ddr_writeback_ctrl_pkg::*;
#(
   parameter int  WIDTH = 128,
   parameter int  DEPTH = 4,
   localparam int AW    = clogb2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_wr, do_rd;

   assign do_wr = wr_i && (count_q != CW'(DEPTH));
   assign do_rd = rd_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;

endmodule

// File: rtl/ob_ddr_writeback_ctrl.sv
// Drains word_num consecutive output-buffer words into the DDR write FIFO after a
// one-cycle write-transaction configuration pulse, honouring OB read latency and FIFO backpressure.
module ob_ddr_writeback_ctrl
   import ob_ddr_writeback_ctrl_pkg::*;
#(
   parameter int DDR_ADDR_LEN = 32,
   parameter int ADDR_LEN     = 16,
   parameter int DATA_LEN     = 64,
   parameter int BUFFER_NUM   = 2,
   parameter int SINGLE_LEN   = 24,
   parameter int RD_LATENCY   = 2,
   parameter int LF_DEPTH     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    conf_i,
   input  logic [SINGLE_LEN-1:0]   word_num_i,
   input  logic [SINGLE_LEN-1:0]   ddr_byte_i,
   input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_i,
   input  logic [ADDR_LEN-1:0]     ob_st_addr_i,
   output logic                    idle_o,
   output logic                    done_o,
   ob_ddr_writeback_ctrl_if.master bus
);

   localparam int W     = word_width(DATA_LEN, BUFFER_NUM);
   localparam int LF_CW = clogb2(LF_DEPTH) + 1;

   wb_state_e               state_q,       state_d;
   logic [SINGLE_LEN-1:0]   word_num_q,    word_num_d;
   logic [ADDR_LEN-1:0]     ob_st_addr_q,  ob_st_addr_d;
   logic [DDR_ADDR_LEN-1:0] ddr_addr_q,    ddr_addr_d;
   logic [SINGLE_LEN-1:0]   ddr_len_q,     ddr_len_d;
   logic [SINGLE_LEN-1:0]   issued_q,      issued_d;
   logic [SINGLE_LEN-1:0]   pushed_q,      pushed_d;
   logic [RD_LATENCY-1:0]   rd_vld_q,      rd_vld_d;

   logic                    issue, push, done, credit_ok;
   logic [SINGLE_LEN-1:0]   pushed_inc;
   logic                    lf_empty;
   logic [LF_CW-1:0]        lf_count;
   logic [W-1:0]            lf_head;
   int                      rd_cnt;

   ob_ddr_writeback_ctrl_sync_skid_fifo #(
      .WIDTH (W),
      .DEPTH (LF_DEPTH)
   ) u_lf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (rd_vld_q[RD_LATENCY-1]),
      .wr_data_i (bus.ob_data),
      .rd_i      (push),
      .rd_data_o (lf_head),
      .empty_o   (lf_empty),
      .count_o   (lf_count)
   );

   // Reads in flight plus buffered words never exceed LF depth, so returns always fit.
   always_comb begin
      rd_cnt = 0;
      for (int i = 0; i < RD_LATENCY; i++) rd_cnt += int'(rd_vld_q[i]);
      credit_ok = (rd_cnt + int'(lf_count)) < LF_DEPTH;
   end

   assign push       = !lf_empty && !bus.ddr_fifo_full;
   assign pushed_inc = push ? pushed_q + SINGLE_LEN'(1) : pushed_q;

   always_comb begin
      state_d      = state_q;
      word_num_d   = word_num_q;
      ob_st_addr_d = ob_st_addr_q;
      ddr_addr_d   = ddr_addr_q;
      ddr_len_d    = ddr_len_q;
      issued_d     = issued_q;
      pushed_d     = pushed_inc;
      issue        = 1'b0;
      done         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (conf_i) begin
               word_num_d   = word_num_i;
               ob_st_addr_d = ob_st_addr_i;
               ddr_addr_d   = ddr_st_addr_i;
               ddr_len_d    = ddr_byte_i;
               issued_d     = '0;
               pushed_d     = '0;
               // An empty job skips the DDR handshake and finishes from FLUSH next cycle.
               state_d      = (word_num_i == '0) ? ST_FLUSH : ST_START;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if ((issued_q < word_num_q) && credit_ok) begin
               issue    = 1'b1;
               issued_d = issued_q + SINGLE_LEN'(1);
               if (issued_d == word_num_q) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (pushed_inc == word_num_q) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rd_vld_d = RD_LATENCY'({rd_vld_q, issue});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         word_num_q   <= '0;
         ob_st_addr_q <= '0;
         ddr_addr_q   <= '0;
         ddr_len_q    <= '0;
         issued_q     <= '0;
         pushed_q     <= '0;
         rd_vld_q     <= '0;
      end else begin
         state_q      <= state_d;
         word_num_q   <= word_num_d;
         ob_st_addr_q <= ob_st_addr_d;
         ddr_addr_q   <= ddr_addr_d;
         ddr_len_q    <= ddr_len_d;
         issued_q     <= issued_d;
         pushed_q     <= pushed_d;
         rd_vld_q     <= rd_vld_d;
      end
   end

   assign bus.ddr_st_addr_out = ddr_addr_q;
   assign bus.ddr_len         = ddr_len_q;
   assign bus.ddr_conf        = (state_q == ST_START);
   assign bus.ddr_fifo_wr     = push;
   assign bus.ddr_fifo_data   = lf_head;
   assign bus.ob_en           = issue;
   assign bus.ob_addr         = ob_st_addr_q + ADDR_LEN'(issued_q);
   assign idle_o              = (state_q == ST_IDLE);
   assign done_o              = done;

endmodule

// File: tb/tb_ob_ddr_writeback_ctrl.sv
// Scoreboard bench for ob_ddr_writeback_ctrl: directed jobs push expected DDR config,
// OB read addresses and pushed words; a negedge monitor pops and compares them.
module tb_ob_ddr_writeback_ctrl;
   localparam int RD_LAT = 2;
   localparam int LFD    = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        conf_i;
   logic [23:0] word_num_i, ddr_byte_i;
   logic [31:0] ddr_st_addr_i;
   logic [15:0] ob_st_addr_i;
   logic        idle_o, done_o;

   ob_ddr_writeback_ctrl_if #(.DDR_ADDR_LEN(32), .ADDR_LEN(16), .SINGLE_LEN(24), .W(128)) bus_if ();

   ob_ddr_writeback_ctrl #(.RD_LATENCY(RD_LAT), .LF_DEPTH(LFD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .conf_i        (conf_i),
      .word_num_i    (word_num_i),
      .ddr_byte_i    (ddr_byte_i),
      .ddr_st_addr_i (ddr_st_addr_i),
      .ob_st_addr_i  (ob_st_addr_i),
      .idle_o        (idle_o),
      .done_o        (done_o),
      .bus           (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int done_seen = 0, pushes = 0, rd_issued = 0;
   logic [15:0] salt;
   bit full_mode = 0, zero_job = 0;
   logic [55:0]  exp_conf [$];
   logic [15:0]  exp_rd   [$];
   logic [127:0] exp_data [$];
   logic [55:0]  ec;
   logic [15:0]  ea;
   logic [127:0] ed;
   logic [127:0] ob_pipe [RD_LAT];

   function automatic logic [127:0] mkword(input logic [15:0] a);
      return {salt, a, ~a, salt, a, ~a, 32'hDEAD_BEEF};
   endfunction

   task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // OB memory model: word contents depend on address and the current job salt.
   always @(posedge clk) begin
      ob_pipe[0] <= bus_if.ob_en ? mkword(bus_if.ob_addr) : '0;
      for (int i = 1; i < RD_LAT; i++) ob_pipe[i] <= ob_pipe[i-1];
   end
   assign bus_if.ob_data = ob_pipe[RD_LAT-1];

   initial begin
      int phase;
      phase = 0;
      bus_if.ddr_fifo_full = 1'b0;
      forever begin
         tick();
         if (full_mode) begin
            phase = (phase + 1) % 5;
            bus_if.ddr_fifo_full = (phase < 3);
         end else begin
            phase = 0;
            bus_if.ddr_fifo_full = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_conf.delete();
         exp_rd.delete();
         exp_data.delete();
         rd_issued = 0;
         pushes    = 0;
      end else begin
         if (bus_if.ddr_conf) begin
            if (exp_conf.size() == 0) check(1'b0, "ddr_conf_unexpected", {bus_if.ddr_st_addr_out, bus_if.ddr_len}, 0);
            else begin
               ec = exp_conf.pop_front();
               check({bus_if.ddr_st_addr_out, bus_if.ddr_len} == ec, "ddr_conf_addr_len", {bus_if.ddr_st_addr_out, bus_if.ddr_len}, ec);
            end
         end
         if (bus_if.ob_en) begin
            check((rd_issued - pushes) < LFD, "credit_limit", rd_issued - pushes, LFD - 1);
            if (exp_rd.size() == 0) check(1'b0, "ob_read_unexpected", bus_if.ob_addr, 0);
            else begin
               ea = exp_rd.pop_front();
               check(bus_if.ob_addr == ea, "ob_addr", bus_if.ob_addr, ea);
            end
            rd_issued++;
         end
         if (bus_if.ddr_fifo_wr) begin
            check(!bus_if.ddr_fifo_full, "push_while_full", bus_if.ddr_fifo_full, 0);
            if (exp_data.size() == 0) check(1'b0, "push_unexpected", bus_if.ddr_fifo_data, 0);
            else begin
               ed = exp_data.pop_front();
               check(bus_if.ddr_fifo_data == ed, "push_data", bus_if.ddr_fifo_data, ed);
            end
            pushes++;
         end
         if (done_o) begin
            check((exp_data.size() == 0) && (bus_if.ddr_fifo_wr || zero_job), "done_with_last_push", exp_data.size(), 0);
            done_seen++;
         end
      end
   end

   task automatic start_job(input logic [31:0] da, input int n, input logic [15:0] oa);
      if (n > 0) exp_conf.push_back({da, 24'(n * 16)});
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(oa + 16'(i));
         exp_data.push_back(mkword(oa + 16'(i)));
      end
      conf_i        = 1'b1;
      word_num_i    = 24'(n);
      ddr_byte_i    = 24'(n * 16);
      ddr_st_addr_i = da;
      ob_st_addr_i  = oa;
      tick();
      conf_i = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_seen < target && n < 2000) begin
         tick();
         n++;
      end
      check(done_seen == target, "done_count", done_seen, target);
      tick();
      check(idle_o == 1'b1, "idle_after_job", idle_o, 1);
      check(exp_data.size() == 0 && exp_rd.size() == 0 && exp_conf.size() == 0, "queues_drained",
            exp_data.size() + exp_rd.size() + exp_conf.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check(idle_o == 1'b1,                  {tag, "_idle"},    idle_o, 1);
      check(done_o == 1'b0,                  {tag, "_done"},    done_o, 0);
      check(bus_if.ddr_conf == 1'b0,         {tag, "_conf"},    bus_if.ddr_conf, 0);
      check(bus_if.ddr_fifo_wr == 1'b0,      {tag, "_wr"},      bus_if.ddr_fifo_wr, 0);
      check(bus_if.ob_en == 1'b0,            {tag, "_ob_en"},   bus_if.ob_en, 0);
      check(bus_if.ob_addr == 16'h0,         {tag, "_ob_addr"}, bus_if.ob_addr, 0);
      check(bus_if.ddr_st_addr_out == 32'h0, {tag, "_ddr_addr"}, bus_if.ddr_st_addr_out, 0);
      check(bus_if.ddr_len == 24'h0,         {tag, "_ddr_len"}, bus_if.ddr_len, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int exp_done, base, n, done_before;
      rst_n = 1'b0; conf_i = 1'b0; word_num_i = '0; ddr_byte_i = '0;
      ddr_st_addr_i = '0; ob_st_addr_i = '0; salt = 16'h1111;
      exp_done = 0;
      repeat (3) tick();
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Basic transfer
      base = pushes;
      start_job(32'h8000_0000, 8, 16'h0010);
      exp_done++;
      wait_done(exp_done);
      check(pushes - base == 8, "basic_push_count", pushes - base, 8);

      // Backpressure with full toggling 3 high / 2 low
      salt = 16'h2222; full_mode = 1; base = pushes;
      start_job(32'h8000_1000, 16, 16'h0100);
      exp_done++;
      wait_done(exp_done);
      full_mode = 0;
      check(pushes - base == 16, "bp_push_count", pushes - base, 16);

      // Zero-length job
      zero_job = 1; base = pushes;
      start_job(32'h9000_0000, 0, 16'h0200);
      @(negedge clk);
      check(done_o == 1'b1, "zero_len_done", done_o, 1);
      exp_done++;
      @(posedge clk); #1;
      wait_done(exp_done);
      zero_job = 0;
      check(pushes == base, "zero_len_no_push", pushes - base, 0);

      // Address wrap-around
      salt = 16'h3333;
      start_job(32'h8000_2000, 4, 16'hFFFE);
      exp_done++;
      wait_done(exp_done);

      // Reset mid-job after 5 pushes
      salt = 16'h5555; base = pushes;
      start_job(32'h8000_3000, 20, 16'h0300);
      n = 0;
      while ((pushes - base) < 5 && n < 500) begin
         tick();
         n++;
      end
      check((pushes - base) >= 5, "reset_wait_5_pushes", pushes - base, 5);
      done_before = done_seen;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      repeat (5) tick();
      check(done_seen == done_before, "no_done_on_reset", done_seen, done_before);
      salt = 16'h6666; base = pushes;
      start_job(32'h8000_4000, 3, 16'h0400);
      exp_done++;
      wait_done(exp_done);
      check(pushes - base == 3, "post_reset_push_count", pushes - base, 3);

      // conf while busy is ignored
      salt = 16'h7777;
      start_job(32'h8000_5000, 12, 16'h0500);
      repeat (4) tick();
      conf_i = 1'b1; word_num_i = 24'd5; ddr_byte_i = 24'd80;
      ddr_st_addr_i = 32'hDEAD_0000; ob_st_addr_i = 16'h0900;
      tick();
      conf_i = 1'b0;
      check(bus_if.ddr_st_addr_out == 32'h8000_5000, "busy_conf_addr_held", bus_if.ddr_st_addr_out, 32'h8000_5000);
      exp_done++;
      wait_done(exp_done);
      check(bus_if.ddr_len == 24'd192, "busy_conf_len_held", bus_if.ddr_len, 24'd192);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ob_ddr_writeback_ctrl.md
Name: ob_ddr_writeback_ctrl

Overview:
Drains a block of result words from the on-chip output buffer (OB) into the DDR write-side FIFO. This is the inverse of the bias/weight DDR-to-buffer loaders.
On `conf` it latches a job, issues a one-cycle DDR write-transaction configuration pulse, then streams `word_num` consecutive OB words into the DDR FIFO. It honours the fixed BRAM read latency and `ddr_fifo_full` backpressure without losing or duplicating words. It sits between the PE output buffers and the DDR write master.

Parameters:
- DDR_ADDR_LEN, 32, DDR byte-address width
- ADDR_LEN, 16, OB word-address width
- DATA_LEN, 64, width of one OB bank
- BUFFER_NUM, 2, OB banks read in parallel; word width W = DATA_LEN*BUFFER_NUM
- SINGLE_LEN, 24, width of word/byte counts
- RD_LATENCY, 2, OB read latency in cycles (address to data), 1..4
- LF_DEPTH, 4, local skid FIFO depth; must be >= RD_LATENCY+1, power of 2

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- conf  in  1  job start pulse; sampled only when idle
- word_num  in  SINGLE_LEN  OB words to transfer
- ddr_byte  in  SINGLE_LEN  DDR transaction length in bytes (= word_num*W/8, supplied by the scheduler)
- ddr_st_addr  in  DDR_ADDR_LEN  DDR destination byte address
- ob_st_addr  in  ADDR_LEN  first OB word address
- ddr_st_addr_out  out  DDR_ADDR_LEN  latched DDR address to write master
- ddr_len  out  SINGLE_LEN  latched byte length to write master
- ddr_conf  out  1  one-cycle write-transaction start pulse
- ddr_fifo_full  in  1  DDR write FIFO full
- ddr_fifo_wr  out  1  DDR write FIFO push strobe
- ddr_fifo_data  out  W  push data
- ob_addr  out  ADDR_LEN  OB read address
- ob_en  out  1  OB read enable
- ob_data  in  W  OB read data, valid RD_LATENCY cycles after ob_en
- idle  out  1  high when no job is active
- done  out  1  one-cycle pulse when the final word is pushed

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state. Outputs after reset: ddr_st_addr_out=0, ddr_len=0, ddr_conf=0, ddr_fifo_wr=0, ddr_fifo_data=don't-care, ob_addr=0, ob_en=0, idle=1, done=0. The local FIFO (LF) is emptied and the read-valid shift register is cleared, so in-flight reads are discarded. Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, START, RUN, FLUSH.
- IDLE: idle=1. On conf, latch all inputs, clear counters issued=0 and pushed=0, and go to START. If word_num=0, go directly to a single cycle that asserts done and return to IDLE; no ddr_conf.
- START (1 cycle): ddr_conf=1 with ddr_st_addr_out/ddr_len valid; go to RUN. ddr_st_addr_out and ddr_len hold their values until the next accepted conf.
- RUN: issue a read (ob_en=1, ob_addr=ob_st_addr+issued, issued++) when issued<word_num and (reads in flight + LF occupancy) < LF_DEPTH. This credit rule guarantees LF never overflows. When issued reaches word_num, go to FLUSH.
- Read return: a RD_LATENCY-deep valid shift register tags returning ob_data, which is written into LF.
- Push rule (combinational): ddr_fifo_wr = LF not empty AND NOT ddr_fifo_full. ddr_fifo_data = LF head. On each push, pop LF and increment pushed.
- FLUSH: no new reads. When a push makes pushed==word_num, assert done the same cycle and go to IDLE. idle returns high the following cycle.
- Ordering: words are pushed strictly in OB address order. Exactly word_num pushes per job.
- ob_addr wraps modulo 2^ADDR_LEN. Counters are SINGLE_LEN wide, with no overflow since word_num < 2^SINGLE_LEN.
- conf while not idle is ignored.
- LF full and a return in the same cycle cannot occur, by the credit rule. An LF push and pop in the same cycle leaves occupancy unchanged.
- Peak throughput is 1 word/cycle with full deasserted.

Decomposition:
- Shared package (buffer_ctrl_pkg): FSM state encoding, clogb2 function, W derivation.
- One sub-module: sync_skid_fifo (parameterised width/depth, registered storage, first-word-fall-through head, count output). It is reused for LF.

Test Plan:
1. Basic transfer: RD_LATENCY=2, word_num=8, ob_st_addr=0x0010, ddr_st_addr=0x8000_0000, ddr_byte=128, full=0. Required: one ddr_conf carrying 0x8000_0000/128; 8 pushes of OB[0x10..0x17] in order; done coincides with the 8th push.
2. Backpressure: word_num=16, ddr_fifo_full toggling 3 cycles high / 2 cycles low. Required: exactly 16 pushes in order; no push while full=1; ob_en stalls once LF plus in-flight reads reach 4.
3. Zero-length job: word_num=0. Required: done one cycle after conf; no ddr_conf, ob_en or ddr_fifo_wr.
4. Wrap-around: ob_st_addr=0xFFFE, word_num=4. Required: reads from 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. Reset mid-job: rst_n low for 1 cycle after 5 of 20 words are pushed. Required: all outputs return to reset values, no done pulse, idle=1. A new job word_num=3 then completes correctly with no stale data.
6. conf while busy: a second conf mid-job. Required: ignored; ddr_st_addr_out unchanged; the current job completes normally.
